// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM encoding and op-class helpers for the EX-stage multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] MD_NOP   = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MADD  = 3'd5;
  localparam logic [2:0] MD_MSUB  = 3'd6;
  // MTLO shares this code; RT_In[0]=1 selects LO, 0 selects HI.
  localparam logic [2:0] MD_MTHI  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FINAL = 2'd2
  } md_state_e;

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD) || (op == MD_MSUB);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One radix-2 step: shift-add multiply on {upper, multiplier} or restoring
// divide on {remainder, quotient}. Purely combinational.
module muldiv_iter_core #(
  parameter int DATA_W = 32
) (
  input  logic                  div_mode_i,
  input  logic [2*DATA_W-1:0]   acc_i,
  input  logic [DATA_W-1:0]     operand_i,
  output logic [2*DATA_W-1:0]   acc_o
);

  logic [DATA_W-1:0] hi_part;
  logic [DATA_W-1:0] lo_part;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   rem_sh;
  logic [DATA_W-1:0] diff;
  logic              fits;

  assign hi_part = acc_i[2*DATA_W-1:DATA_W];
  assign lo_part = acc_i[DATA_W-1:0];

  assign sum    = {1'b0, hi_part} + (lo_part[0] ? {1'b0, operand_i} : '0);
  // Shifted remainder needs DATA_W+1 bits; the difference fits DATA_W when it is kept.
  assign rem_sh = {hi_part, lo_part[DATA_W-1]};
  assign fits   = (rem_sh >= {1'b0, operand_i});
  assign diff   = rem_sh[DATA_W-1:0] - operand_i;

  always_comb begin
    acc_o = {sum, lo_part[DATA_W-1:1]};
    if (div_mode_i) begin
      if (fits) acc_o = {diff, lo_part[DATA_W-2:0], 1'b1};
      else      acc_o = {rem_sh[DATA_W-1:0], lo_part[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide with HI/LO registers; stalls HI/LO readers
// and later mul/div ops while an iterative op is in flight.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start_In,
  input  logic [2:0]        MD_Op_In,
  input  logic [DATA_W-1:0] RS_In,
  input  logic [DATA_W-1:0] RT_In,
  input  logic              HiLoRead_In,
  output logic [DATA_W-1:0] Hi_Out,
  output logic [DATA_W-1:0] Lo_Out,
  output logic              Busy_Out,
  output logic              Stall_Out
);

  md_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic                neg_res_q, neg_res_d;
  logic                neg_rem_q, neg_rem_d;
  logic                dz_q, dz_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;

  logic [2*DATA_W-1:0] core_acc;
  logic                sgn_op;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [2*DATA_W-1:0] prod_s, mul_res;
  logic [DATA_W-1:0]   quo, rem, quo_fix, rem_fix;

  muldiv_iter_core #(.DATA_W(DATA_W)) u_core (
    .div_mode_i (md_is_div(op_q)),
    .acc_i      (acc_q),
    .operand_i  (b_q),
    .acc_o      (core_acc)
  );

  assign sgn_op = md_is_signed(MD_Op_In);
  assign a_mag  = (sgn_op && RS_In[DATA_W-1]) ? -RS_In : RS_In;
  assign b_mag  = (sgn_op && RT_In[DATA_W-1]) ? -RT_In : RT_In;

  assign prod_s  = neg_res_q ? -acc_q : acc_q;
  assign quo     = acc_q[DATA_W-1:0];
  assign rem     = acc_q[2*DATA_W-1:DATA_W];
  // Divide-by-zero leaves remainder = |dividend|, so the sign fix restores RS_In in HI.
  assign quo_fix = dz_q ? '1 : (neg_res_q ? -quo : quo);
  assign rem_fix = neg_rem_q ? -rem : rem;

  always_comb begin
    mul_res = prod_s;
    if (op_q == MD_MADD)      mul_res = {hi_q, lo_q} + prod_s;
    else if (op_q == MD_MSUB) mul_res = {hi_q, lo_q} - prod_s;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    acc_d     = acc_q;
    b_d       = b_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (Start_In) begin
          case (MD_Op_In)
            MD_NOP: ;
            MD_MTHI: begin
              if (RT_In[0]) lo_d = RS_In;
              else          hi_d = RS_In;
            end
            default: begin
              op_d      = MD_Op_In;
              cnt_d     = '0;
              state_d   = ST_RUN;
              neg_res_d = sgn_op & (RS_In[DATA_W-1] ^ RT_In[DATA_W-1]);
              neg_rem_d = sgn_op & RS_In[DATA_W-1];
              dz_d      = (RT_In == '0);
              if (md_is_div(MD_Op_In)) begin
                acc_d = {{DATA_W{1'b0}}, a_mag};
                b_d   = b_mag;
              end else begin
                acc_d = {{DATA_W{1'b0}}, b_mag};
                b_d   = a_mag;
              end
            end
          endcase
        end
      end
      ST_RUN: begin
        acc_d = core_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = ST_FINAL;
      end
      ST_FINAL: begin
        if (md_is_div(op_q)) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = mul_res[2*DATA_W-1:DATA_W];
          lo_d = mul_res[DATA_W-1:0];
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= MD_NOP;
      acc_q     <= '0;
      b_q       <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign Hi_Out    = hi_q;
  assign Lo_Out    = lo_q;
  assign Busy_Out  = (state_q != ST_IDLE);
  assign Stall_Out = Busy_Out & (HiLoRead_In | Start_In) & ~Reset;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: hand-computed HI/LO results, busy latency,
// stall window, ignored start while busy, and reset mid-operation.
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        hilo_rd;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_n;

  ex_muldiv_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .Clock       (clk),
    .Reset       (rst),
    .Start_In    (start),
    .MD_Op_In    (op),
    .RS_In       (rs),
    .RT_In       (rt),
    .HiLoRead_In (hilo_rd),
    .Hi_Out      (hi),
    .Lo_Out      (lo),
    .Busy_Out    (busy),
    .Stall_Out   (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Presents one op for one cycle, then counts busy cycles (bounded).
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int nb);
    @(negedge clk);
    start = 1'b1; op = o; rs = a; rt = b;
    @(negedge clk);
    start = 1'b0; op = MD_NOP;
    nb = 0;
    while (busy && nb < 100) begin
      nb++;
      @(negedge clk);
    end
  endtask

  task automatic op_check(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
    int nb;
    do_op(o, a, b, nb);
    check_eq({tag, "_hilo"}, {hi, lo}, {exp_hi, exp_lo});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = MD_NOP; rs = '0; rt = '0; hilo_rd = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_hilo", {hi, lo}, 64'd0);
    hilo_rd = 1'b1;
    #1 check_eq("rst_stall", {63'd0, stall}, 64'd0);
    hilo_rd = 1'b0;
    rst = 1'b0;

    // MULT latency and result
    do_op(MD_MULT, 32'd7, 32'hFFFF_FFFD, busy_n);
    check_eq("mult_busy_cycles", 64'(busy_n), 64'd33);
    check_eq("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    op_check("divu_100_7", MD_DIVU, 32'd100, 32'd7, 32'h2, 32'hE);
    op_check("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    op_check("div_100_m7", MD_DIV, 32'd100, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFF2);
    op_check("divu_by0", MD_DIVU, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF);
    op_check("div_neg_by0", MD_DIV, 32'hFFFF_EDCC, 32'd0, 32'hFFFF_EDCC, 32'hFFFF_FFFF);
    do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, busy_n);
    check_eq("div_ovf_busy_cycles", 64'(busy_n), 64'd33);
    check_eq("div_ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);
    op_check("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1);
    op_check("mult_minmin", MD_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);

    // MTHI / MTLO / MADD / MSUB
    do_op(MD_MTHI, 32'd0, 32'd0, busy_n);
    check_eq("mthi_busy_cycles", 64'(busy_n), 64'd0);
    do_op(MD_MTHI, 32'd10, 32'd1, busy_n);
    check_eq("mtlo_hilo", {hi, lo}, 64'd10);
    op_check("madd_3_4", MD_MADD, 32'd3, 32'd4, 32'h0, 32'd22);
    op_check("msub_5_5", MD_MSUB, 32'd5, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // Stall window and ignored start while busy; cycle c follows start edge E0
    @(negedge clk);
    start = 1'b1; op = MD_MULT; rs = 32'd7; rt = 32'hFFFF_FFFD;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      hilo_rd = (c >= 5);
      start   = (c == 10);
      op      = (c == 10) ? MD_DIVU : MD_NOP;
      rs      = (c == 10) ? 32'd5 : 32'd0;
      rt      = 32'd0;
      #1;
      if (c == 4 || c == 5 || c == 10 || c == 33 || c == 34)
        check_eq($sformatf("stall_c%0d", c), {63'd0, stall}, {63'd0, (c >= 5 && c <= 33)});
    end
    hilo_rd = 1'b0;
    check_eq("stall_test_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    @(negedge clk);
    check_eq("ignored_start_busy", {63'd0, busy}, 64'd0);

    // Reset mid-divide
    @(negedge clk);
    start = 1'b1; op = MD_DIVU; rs = 32'd100; rt = 32'd7;
    @(negedge clk);
    start = 1'b0; op = MD_NOP;
    repeat (9) @(negedge clk);
    rst = 1'b1; hilo_rd = 1'b1;
    #1 check_eq("stall_in_reset", {63'd0, stall}, 64'd0);
    @(negedge clk);
    rst = 1'b0; hilo_rd = 1'b0;
    check_eq("midrst_busy", {63'd0, busy}, 64'd0);
    check_eq("midrst_hilo", {hi, lo}, 64'd0);
    op_check("multu_after_rst", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h1, 32'hFFFF_FFFE);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
